eq_mag_comparator: RTL and testbench

//   Registered equality/magnitude comparator for two WIDTH-bit operands x and y.
//   z asserts when x == y; lt and gt report ordering, unsigned or signed per SIGNED.

---
 rtl/eq_mag_comparator.sv | 72 +++++++
 tb/tb_eq_mag_comparator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/eq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : eq_mag_comparator
//  Purpose  : Registered equality / magnitude comparator with valid strobe.
//             z = (x == y); lt / gt give unsigned or two's-complement order.
//             One cycle of latency, accepts a new compare every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module eq_mag_comparator #(
   parameter int WIDTH  = 1,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             z,
   output logic             lt,
   output logic             gt
);

   localparam int MSB = WIDTH - 1;

   // Ordering keys. A two's-complement order equals the unsigned order of the
   // operands with their sign bit inverted, so the signed case is folded onto
   // a single unsigned magnitude compare.
   logic [WIDTH-1:0] x_key;
   logic [WIDTH-1:0] y_key;

   generate
      if (SIGNED) begin : g_signed
         localparam logic [WIDTH-1:0] SIGN_FLIP = WIDTH'(1) << MSB;
         assign x_key = x ^ SIGN_FLIP;
         assign y_key = y ^ SIGN_FLIP;
      end else begin : g_unsigned
         assign x_key = x;
         assign y_key = y;
      end
   endgenerate

   logic eq_now;
   logic lt_now;
   logic gt_now;

   // Combinational compare straight from the ports; exactly one flag is set.
   always_comb begin
      eq_now = (x == y);
      lt_now = (x_key < y_key);
      gt_now = !eq_now && !lt_now;
   end

   // Result registers: reset clears all, valid loads, otherwise flags hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         z         <= 1'b0;
         lt        <= 1'b0;
         gt        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            z  <= eq_now;
            lt <= lt_now;
            gt <= gt_now;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eq_mag_comparator
//  Purpose  : Self-checking bench for eq_mag_comparator. Six instances cover
//             WIDTH 1/4/8 in unsigned and signed modes, driven in parallel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eq_mag_comparator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] x;
   logic [7:0] y;
   logic [5:0] ov;
   logic [5:0] zz;
   logic [5:0] ll;
   logic [5:0] gg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   eq_mag_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_w1u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x[0:0]), .y(y[0:0]),
      .out_valid(ov[0]), .z(zz[0]), .lt(ll[0]), .gt(gg[0]));
   eq_mag_comparator #(.WIDTH(1), .SIGNED(1'b1)) u_w1s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x[0:0]), .y(y[0:0]),
      .out_valid(ov[1]), .z(zz[1]), .lt(ll[1]), .gt(gg[1]));
   eq_mag_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x[3:0]), .y(y[3:0]),
      .out_valid(ov[2]), .z(zz[2]), .lt(ll[2]), .gt(gg[2]));
   eq_mag_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x[3:0]), .y(y[3:0]),
      .out_valid(ov[3]), .z(zz[3]), .lt(ll[3]), .gt(gg[3]));
   eq_mag_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
      .out_valid(ov[4]), .z(zz[4]), .lt(ll[4]), .gt(gg[4]));
   eq_mag_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
      .out_valid(ov[5]), .z(zz[5]), .lt(ll[5]), .gt(gg[5]));

   typedef struct {
      logic [5:0] ov;
      logic [5:0] z;
      logic [5:0] lt;
      logic [5:0] gt;
   } exp_t;

   exp_t       sb[$];
   logic [5:0] m_z;
   logic [5:0] m_lt;
   logic [5:0] m_gt;

   function automatic int wid(input int i);
      return (i < 2) ? 1 : (i < 4) ? 4 : 8;
   endfunction

   function automatic bit sgn(input int i);
      return (i % 2) == 1;
   endfunction

   // Operand value as an integer: masked to the width, sign-extended if signed.
   function automatic int val(input logic [7:0] a, input int w, input bit s);
      int v;
      v = int'(a) & ((1 << w) - 1);
      if (s && (((v >> (w - 1)) & 1) == 1)) v = v - (1 << w);
      return v;
   endfunction

   // Pop the expected outputs for this edge and compare every instance.
   task automatic check_outputs();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty obs=0 exp=1");
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < 6; i++) begin
         checks++;
         assert ({ov[i], zz[i], ll[i], gg[i]} === {e.ov[i], e.z[i], e.lt[i], e.gt[i]})
         else begin
            errors++;
            $error("FAIL result_w%0d_s%0d x=%h y=%h obs(ov,z,lt,gt)=%b exp=%b",
                   wid(i), sgn(i), x, y, {ov[i], zz[i], ll[i], gg[i]},
                   {e.ov[i], e.z[i], e.lt[i], e.gt[i]});
         end
         if (ov[i] === 1'b1) begin
            checks++;
            assert ($countones({zz[i], ll[i], gg[i]}) == 1)
            else begin
               errors++;
               $error("FAIL onehot_w%0d_s%0d obs(z,lt,gt)=%b exp=one-hot",
                      wid(i), sgn(i), {zz[i], ll[i], gg[i]});
            end
         end
      end
   endtask

   // Drive one cycle, push the modelled result, then check it after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] a,
                       input logic [7:0] b);
      exp_t e;
      int   xa;
      int   yb;
      @(negedge clk);
      rst      = r;
      in_valid = v;
      x        = a;
      y        = b;
      for (int i = 0; i < 6; i++) begin
         if (r) begin
            m_z[i] = 1'b0; m_lt[i] = 1'b0; m_gt[i] = 1'b0;
            e.ov[i] = 1'b0;
         end else if (v) begin
            xa = val(a, wid(i), sgn(i));
            yb = val(b, wid(i), sgn(i));
            m_z[i]  = (xa == yb);
            m_lt[i] = (xa < yb);
            m_gt[i] = (xa > yb);
            e.ov[i] = 1'b1;
         end else begin
            e.ov[i] = 1'b0;
         end
      end
      e.z  = m_z;
      e.lt = m_lt;
      e.gt = m_gt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
      m_z = '0; m_lt = '0; m_gt = '0;
      // Reset state
      step(1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b1, 8'h12, 8'h34);
      // Equal operands
      step(1'b0, 1'b1, 8'h01, 8'h01);
      // Back-to-back (0,0),(1,0),(0,1)
      step(1'b0, 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b1, 8'h01, 8'h00);
      step(1'b0, 1'b1, 8'h00, 8'h01);
      // Sign-sensitive operands and equal negative values
      step(1'b0, 1'b1, 8'h0F, 8'h01);
      step(1'b0, 1'b1, 8'hFF, 8'h01);
      step(1'b0, 1'b1, 8'h08, 8'h08);
      step(1'b0, 1'b1, 8'h80, 8'h7F);
      step(1'b0, 1'b1, 8'h7F, 8'h80);
      // Hold while invalid after an equal result
      step(1'b0, 1'b1, 8'h05, 8'h05);
      step(1'b0, 1'b0, 8'h03, 8'h05);
      step(1'b0, 1'b0, 8'hF0, 8'h01);
      // Hold after a less-than result
      step(1'b0, 1'b1, 8'h01, 8'h02);
      step(1'b0, 1'b0, 8'h02, 8'h02);
      // Reset overrides valid, then recovery
      step(1'b1, 1'b1, 8'h44, 8'h44);
      step(1'b0, 1'b1, 8'h09, 8'h03);
      step(1'b0, 1'b1, 8'h03, 8'h09);
      // Random traffic, occasional bubbles and forced equality
      for (int n = 0; n < 300; n++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? ra : 8'($urandom);
         step(1'b0, ($urandom_range(0, 4) != 0), ra, rb);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
